// File: rtl/pkt_copy_ctrl_if.sv
// Bus bundle between the packet-copy controller (slave) and its client/reg_files (master).
interface pkt_copy_ctrl_if #(
  parameter int unsigned pBITS  = 8,
  parameter int unsigned pWIDHT = 2
);
  logic              istart;
  logic [pWIDHT-1:0] isrc_base;
  logic [pWIDHT-1:0] idst_base;
  logic [pWIDHT:0]   ilen;
  logic              ihold;
  logic [pBITS-1:0]  isrc_rdata;
  logic [pWIDHT-1:0] osrc_raddr;
  logic [pWIDHT-1:0] odst_waddr;
  logic [pBITS-1:0]  odst_wdata;
  logic              odst_wen;
  logic              odst_clr;
  logic              ordy;
  logic              odone;
  logic              oerr;

  modport slave (
    input  istart, isrc_base, idst_base, ilen, ihold, isrc_rdata,
    output osrc_raddr, odst_waddr, odst_wdata, odst_wen, odst_clr, ordy, odone, oerr
  );

  modport master (
    output istart, isrc_base, idst_base, ilen, ihold, isrc_rdata,
    input  osrc_raddr, odst_waddr, odst_wdata, odst_wen, odst_clr, ordy, odone, oerr
  );
endinterface

// File: rtl/pkt_copy_ctrl.sv
// Copies ilen words from a source reg_file to a destination reg_file, one word per cycle.
// Optional PKT_COPY_CLR_EN inserts a one-cycle destination clear before the copy.
module pkt_copy_ctrl #(
  parameter int unsigned pBITS  = 8,
  parameter int unsigned pWIDHT = 2
) (
  input  logic           iclk,
  input  logic           irst_n,
  pkt_copy_ctrl_if.slave bus
);
  localparam int unsigned AW = pWIDHT;
  localparam int unsigned LW = pWIDHT + 1;
  localparam logic [LW-1:0] DEPTH = LW'(2 ** pWIDHT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_COPY  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef PKT_COPY_CLR_EN
  localparam state_t S_FIRST = S_CLEAR;
`else
  localparam state_t S_FIRST = S_COPY;
`endif

  state_t           state_q, state_d;
  logic [AW-1:0]    src_base_q, dst_base_q, rcnt_q, waddr_q;
  logic [LW-1:0]    len_q;
  logic [pBITS-1:0] wdata_q;
  logic             wvalid_q, oerr_q;
  logic             len_ok_c, last_c, accept_c, err_c, adv_c, flush_c;

  assign len_ok_c = (bus.ilen != '0) && (bus.ilen <= DEPTH);
  assign last_c   = ({1'b0, rcnt_q} == (len_q - LW'(1)));

  // Next-state and datapath enables
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    err_c    = 1'b0;
    adv_c    = 1'b0;
    flush_c  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.istart) begin
          if (len_ok_c) begin
            accept_c = 1'b1;
            state_d  = S_FIRST;
          end else begin
            err_c = 1'b1;
          end
        end
      end
      S_CLEAR: state_d = S_COPY;
      S_COPY: begin
        if (!bus.ihold) begin
          adv_c = 1'b1;
          if (last_c) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!bus.ihold) begin
          flush_c = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and the write register
  always_ff @(posedge iclk) begin
    if (!irst_n) begin
      state_q    <= S_IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      rcnt_q     <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wvalid_q   <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      oerr_q  <= err_c;
      if (accept_c) begin
        src_base_q <= bus.isrc_base;
        dst_base_q <= bus.idst_base;
        len_q      <= bus.ilen;
        rcnt_q     <= '0;
      end
      if (adv_c) begin
        wdata_q  <= bus.isrc_rdata;
        waddr_q  <= dst_base_q + rcnt_q;
        wvalid_q <= 1'b1;
        rcnt_q   <= rcnt_q + AW'(1);
      end
      if (flush_c) wvalid_q <= 1'b0;
    end
  end

  assign bus.osrc_raddr = src_base_q + rcnt_q;
  assign bus.odst_waddr = waddr_q;
  assign bus.odst_wdata = wdata_q;
  assign bus.odst_wen   = wvalid_q & ~bus.ihold;
  assign bus.ordy       = (state_q == S_IDLE) || (state_q == S_DONE);
  assign bus.odone      = (state_q == S_DONE);
  assign bus.oerr       = oerr_q;
`ifdef PKT_COPY_CLR_EN
  assign bus.odst_clr   = (state_q == S_CLEAR);
`else
  assign bus.odst_clr   = 1'b0;
`endif

endmodule

// File: tb/tb_pkt_copy_ctrl.sv
// Scoreboard bench for pkt_copy_ctrl: stimulus pushes expected events, a negedge monitor pops them.
module tb_pkt_copy_ctrl;
`ifdef PKT_COPY_CLR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  typedef struct {
    int         c;
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  logic iclk = 1'b0;
  logic irst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] src_mem [4];

  wr_t wq[$];
  int  done_q[$];
  int  err_q[$];
  int  clr_q[$];

  pkt_copy_ctrl_if #(.pBITS(8), .pWIDHT(2)) dif ();

  pkt_copy_ctrl #(.pBITS(8), .pWIDHT(2)) dut (
    .iclk  (iclk),
    .irst_n(irst_n),
    .bus   (dif.slave)
  );

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;
  assign dif.isrc_rdata = src_mem[dif.osrc_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event expected none (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  // Expected events for an unstalled copy accepted at the end of cycle c0
  task automatic exp_copy(input int c0, input int s, input int d, input int l);
    wr_t e;
    if (CLR != 0) clr_q.push_back(c0 + 1);
    for (int k = 0; k < l; k++) begin
      e.c = c0 + 2 + CLR + k;
      e.a = 2'((d + k) % 4);
      e.d = src_mem[(s + k) % 4];
      wq.push_back(e);
    end
    done_q.push_back(c0 + l + 2 + CLR);
  endtask

  task automatic go(input int s, input int d, input int l, output int c0);
    dif.istart    = 1'b1;
    dif.isrc_base = 2'(s);
    dif.idst_base = 2'(d);
    dif.ilen      = 3'(l);
    c0 = cyc;
    tick();
    dif.istart = 1'b0;
  endtask

  // Monitor: compare every presented output event against the scoreboard
  always @(negedge iclk) begin
    wr_t e;
    int  c;
    if (dif.odst_wen === 1'b1) begin
      if (wq.size() == 0) unexpected("write");
      else begin
        e = wq.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e.c));
        chk("wr_addr_data", 32'({dif.odst_waddr, dif.odst_wdata}), 32'({e.a, e.d}));
      end
    end
    if (dif.odone === 1'b1) begin
      if (done_q.size() == 0) unexpected("done");
      else begin
        c = done_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(c));
        chk("done_ordy", 32'(dif.ordy), 32'd1);
      end
    end
    if (dif.oerr === 1'b1) begin
      if (err_q.size() == 0) unexpected("err");
      else begin
        c = err_q.pop_front();
        chk("err_cycle", 32'(cyc), 32'(c));
      end
    end
    if (dif.odst_clr === 1'b1) begin
      if (clr_q.size() == 0) unexpected("clr");
      else begin
        c = clr_q.pop_front();
        chk("clr_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  initial begin
    int  c0, c1;
    wr_t e;
    src_mem[0] = 8'hA0; src_mem[1] = 8'hB1; src_mem[2] = 8'hC2; src_mem[3] = 8'hD3;
    irst_n = 1'b0;
    dif.istart = 1'b0; dif.isrc_base = '0; dif.idst_base = '0; dif.ilen = '0; dif.ihold = 1'b0;
    tick(); tick();
    irst_n = 1'b1;

    // Reset state
    chk("rst_ordy",  32'(dif.ordy), 32'd1);
    chk("rst_wen",   32'(dif.odst_wen), 32'd0);
    chk("rst_done",  32'(dif.odone), 32'd0);
    chk("rst_err",   32'(dif.oerr), 32'd0);
    chk("rst_raddr", 32'(dif.osrc_raddr), 32'd0);
    chk("rst_waddr", 32'(dif.odst_waddr), 32'd0);
    chk("rst_wdata", 32'(dif.odst_wdata), 32'd0);
    chk("rst_clr",   32'(dif.odst_clr), 32'd0);
    tick(); tick();
    chk("idle_ordy", 32'(dif.ordy), 32'd1);

    // Basic 4-word copy
    go(0, 0, 4, c0);
    exp_copy(c0, 0, 0, 4);
    run_to(c0 + 10);

    // Address wrap on both sides
    go(3, 2, 3, c0);
    exp_copy(c0, 3, 2, 3);
    run_to(c0 + 9);

    // Hold in cycles 3-4: writes at 2,5,6,7, done at 8
    go(0, 0, 4, c0);
    if (CLR != 0) clr_q.push_back(c0 + 1);
    e.c = c0 + 2 + CLR; e.a = 2'd0; e.d = 8'hA0; wq.push_back(e);
    e.c = c0 + 5 + CLR; e.a = 2'd1; e.d = 8'hB1; wq.push_back(e);
    e.c = c0 + 6 + CLR; e.a = 2'd2; e.d = 8'hC2; wq.push_back(e);
    e.c = c0 + 7 + CLR; e.a = 2'd3; e.d = 8'hD3; wq.push_back(e);
    done_q.push_back(c0 + 8 + CLR);
    while (cyc < c0 + 12) begin
      dif.ihold = (cyc == c0 + 3 + CLR) || (cyc == c0 + 4 + CLR);
      tick();
    end
    dif.ihold = 1'b0;

    // Illegal lengths 0 and 5
    dif.istart = 1'b1; dif.ilen = 3'd0;
    c0 = cyc; err_q.push_back(c0 + 1);
    tick();
    chk("err0_ordy", 32'(dif.ordy), 32'd1);
    dif.ilen = 3'd5;
    c1 = cyc; err_q.push_back(c1 + 1);
    tick();
    dif.istart = 1'b0;
    chk("err5_ordy", 32'(dif.ordy), 32'd1);
    tick(); tick();

    // istart with illegal length mid-copy must be ignored
    go(1, 1, 2, c0);
    exp_copy(c0, 1, 1, 2);
    dif.istart = 1'b1; dif.ilen = 3'd0;
    tick();
    dif.istart = 1'b0;
    run_to(c0 + 9);

    // Reset in cycle 3 of a 4-word copy
    go(0, 0, 4, c0);
    if (CLR != 0) clr_q.push_back(c0 + 1);
    for (int k = 0; k < 4; k++) begin
      if (2 + CLR + k <= 3) begin
        e.c = c0 + 2 + CLR + k; e.a = 2'(k); e.d = src_mem[k]; wq.push_back(e);
      end
    end
    run_to(c0 + 3);
    irst_n = 1'b0;
    tick();
    irst_n = 1'b1;
    chk("midrst_ordy", 32'(dif.ordy), 32'd1);
    chk("midrst_wen",  32'(dif.odst_wen), 32'd0);
    run_to(c0 + 10);

    // Length 1, then a new copy accepted in the DONE cycle
    go(2, 1, 1, c0);
    exp_copy(c0, 2, 1, 1);
    run_to(c0 + 3 + CLR);
    chk("b2b_ordy", 32'(dif.ordy), 32'd1);
    dif.istart = 1'b1; dif.isrc_base = 2'd1; dif.idst_base = 2'd3; dif.ilen = 3'd2;
    c1 = cyc;
    exp_copy(c1, 1, 3, 2);
    tick();
    dif.istart = 1'b0;
    run_to(c1 + 10);

    chk("left_writes", 32'(wq.size()), 32'd0);
    chk("left_done",   32'(done_q.size()), 32'd0);
    chk("left_err",    32'(err_q.size()), 32'd0);
    chk("left_clr",    32'(clr_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
